// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit Galois LFSR generator/checker pair:
// default word width and tap mask, checker state encoding, and the step function.
package lfsr_pkg;

    localparam int             LFSR_WIDTH = 4;
    localparam logic [3:0]     LFSR_POLY  = 4'b0011;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Galois step: shift left, fold the tap mask back in when the MSB falls out.
    function automatic logic [LFSR_WIDTH-1:0] nxt(input logic [LFSR_WIDTH-1:0] cur);
        return {cur[LFSR_WIDTH-2:0], 1'b0} ^ (cur[LFSR_WIDTH-1] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational single-step of a Galois LFSR of arbitrary width and tap mask.
module lfsr_next #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = 4'b0011
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/lfsr_seq_checker.sv
// Receive-side PRBS checker: hunts for lock on the Galois LFSR sequence, then
// flywheels the prediction and flags/counts mismatches. Optional LFSR_CHK_STATS_EN.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] POLY     = LFSR_POLY,
    parameter int               LOCK_CNT = 3,
    parameter int               LOSS_CNT = 2,
    parameter int               ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
`ifdef LFSR_CHK_STATS_EN
    ,
    output logic [31:0]      word_cnt
`endif
);

    localparam int RUN_MAX = (LOCK_CNT + 1 > LOSS_CNT) ? LOCK_CNT + 1 : LOSS_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LOCK  = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] RUN_LOSS  = RUN_W'(LOSS_CNT - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pred_q, pred_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               locked_d;
    logic               pulse_d;
    logic [ERR_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   seed_nxt;
    logic [WIDTH-1:0]   fly_nxt;
    logic               match;

    lfsr_next #(.WIDTH(WIDTH), .POLY(POLY)) u_seed_next (
        .cur (in_data),
        .nxt (seed_nxt)
    );

    lfsr_next #(.WIDTH(WIDTH), .POLY(POLY)) u_fly_next (
        .cur (pred_q),
        .nxt (fly_nxt)
    );

    assign match = (in_data == pred_q);

    always_comb begin
        state_d  = state_q;
        pred_d   = pred_q;
        run_d    = run_q;
        locked_d = locked;
        pulse_d  = 1'b0;
        cnt_d    = err_cnt;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // The all-zero word is the LFSR lock-up state, never a valid seed.
                    if (in_data == '0) begin
                        run_d = '0;
                    end else begin
                        pred_d = seed_nxt;
                        if (run_q != '0 && match) begin
                            if (run_q == RUN_LOCK) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                run_d    = '0;
                            end else begin
                                run_d = run_q + RUN_ONE;
                            end
                        end else begin
                            run_d = RUN_ONE;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel on our own prediction so a corrupted word cannot reseed.
                    pred_d = fly_nxt;
                    if (match) begin
                        run_d = '0;
                    end else begin
                        pulse_d = 1'b1;
                        cnt_d   = sat_inc(err_cnt);
                        if (run_q == RUN_LOSS) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            run_d    = '0;
                        end else begin
                            run_d = run_q + RUN_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            pred_q    <= '0;
            run_q     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            pred_q    <= pred_d;
            run_q     <= run_d;
            locked    <= locked_d;
            err_pulse <= pulse_d;
            err_cnt   <= cnt_d;
        end
    end

`ifdef LFSR_CHK_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
        end else if (in_valid && state_q == LOCKED) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed scoreboard bench for lfsr_seq_checker (default ERR_W and a 2-bit
// saturating instance driven in parallel).
module tb_lfsr_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;

    logic       locked,   err_pulse;
    logic [7:0] err_cnt;
    logic       locked_s, err_pulse_s;
    logic [1:0] err_cnt_s;
`ifdef LFSR_CHK_STATS_EN
    logic [31:0] word_cnt, word_cnt_s;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        lk;
        logic        errp;
        logic [7:0]  c8;
        logic [1:0]  c2;
        logic [31:0] words;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic        m_lk;
    int          m_run;
    logic [3:0]  m_pred;
    logic        m_errp;
    int          m_c8, m_c2;
    logic [31:0] m_words;
    logic [3:0]  g;

    lfsr_seq_checker #(.ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
`ifdef LFSR_CHK_STATS_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    lfsr_seq_checker #(.ERR_W(2)) dut_s (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .locked    (locked_s),
        .err_pulse (err_pulse_s),
        .err_cnt   (err_cnt_s)
`ifdef LFSR_CHK_STATS_EN
        ,
        .word_cnt  (word_cnt_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] bnxt(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lk = 1'b0; m_run = 0; m_pred = 4'd0; m_errp = 1'b0;
        m_c8 = 0; m_c2 = 0; m_words = 32'd0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] d);
        m_errp = 1'b0;
        if (v) begin
            if (!m_lk) begin
                if (d != 4'd0) begin
                    if (m_run > 0 && d == m_pred) m_run++;
                    else m_run = 1;
                    m_pred = bnxt(d);
                    if (m_run == 4) begin m_lk = 1'b1; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end else begin
                m_words++;
                if (d == m_pred) begin
                    m_run = 0;
                end else begin
                    m_errp = 1'b1;
                    if (m_c8 < 255) m_c8++;
                    if (m_c2 < 3) m_c2++;
                    m_run++;
                    if (m_run == 2) begin m_lk = 1'b0; m_run = 0; end
                end
                m_pred = bnxt(m_pred);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        model_step(v, d);
        e.lk = m_lk; e.errp = m_errp; e.c8 = 8'(m_c8); e.c2 = 2'(m_c2); e.words = m_words;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("locked",      32'(locked),      32'(e.lk));
            chk("err_pulse",   32'(err_pulse),   32'(e.errp));
            chk("err_cnt",     32'(err_cnt),     32'(e.c8));
            chk("locked_s",    32'(locked_s),    32'(e.lk));
            chk("err_pulse_s", 32'(err_pulse_s), 32'(e.errp));
            chk("err_cnt_s",   32'(err_cnt_s),   32'(e.c2));
`ifdef LFSR_CHK_STATS_EN
            chk("word_cnt",    word_cnt,         e.words);
            chk("word_cnt_s",  word_cnt_s,       e.words);
`endif
        end
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, g);
            g = bnxt(g);
        end
    endtask

    // Assert reset away from any clock edge and confirm outputs drop at once.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_locked"},   32'(locked),    32'd0);
        chk({tag, "_errp"},     32'(err_pulse), 32'd0);
        chk({tag, "_errcnt"},   32'(err_cnt),   32'd0);
        chk({tag, "_errcnt_s"}, 32'(err_cnt_s), 32'd0);
`ifdef LFSR_CHK_STATS_EN
        chk({tag, "_words"},    word_cnt,       32'd0);
`endif
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked),    32'd0);
        chk("rst_errp",   32'(err_pulse), 32'd0);
        chk("rst_errcnt", 32'(err_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: clean stream locks the cycle after 1000
        g = 4'b0001;
        good(3);
        chk("t1_not_yet", 32'(locked), 32'd0);
        good(1);
        chk("t1_locked", 32'(locked), 32'd1);
        good(1);
        chk("t1_errcnt", 32'(err_cnt), 32'd0);

        // 2: single corrupted word while locked
        chk("t2_expect", 32'(g), 32'b0110);
        drive(1'b1, 4'b0111);
        g = bnxt(g);
        chk("t2_pulse",  32'(err_pulse), 32'd1);
        chk("t2_errcnt", 32'(err_cnt),   32'd1);
        chk("t2_locked", 32'(locked),    32'd1);
        good(1);
        chk("t2_nopulse", 32'(err_pulse), 32'd0);

        // 3: two consecutive bad words drop lock, clean stream relocks after 4
        drive(1'b1, g ^ 4'b0001); g = bnxt(g);
        drive(1'b1, g ^ 4'b0001); g = bnxt(g);
        chk("t3_errcnt", 32'(err_cnt), 32'd3);
        chk("t3_lost",   32'(locked),  32'd0);
        good(3);
        chk("t3_hunting", 32'(locked), 32'd0);
        good(1);
        chk("t3_relock", 32'(locked), 32'd1);

        // 4: valid gaps with junk data across the sequence wrap
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 4'($urandom_range(0, 15)));
            good(1);
        end
        chk("t4_errcnt", 32'(err_cnt), 32'd3);
        chk("t4_locked", 32'(locked),  32'd1);

        // 5: saturation of the 2-bit counter, then async reset mid-stream
        async_reset("t5a");
        good(4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, g ^ 4'b0100); g = bnxt(g);
            good(1);
        end
        chk("t5_sat",     32'(err_cnt_s), 32'd3);
        chk("t5_errcnt",  32'(err_cnt),   32'd4);
        chk("t5_locked",  32'(locked),    32'd1);
`ifdef LFSR_CHK_STATS_EN
        chk("t5_words",   word_cnt,       32'd8);
`endif
        async_reset("t5b");

        // 6: zero words in HUNT never lock
        for (int i = 0; i < 6; i++) drive(1'b1, 4'd0);
        chk("t6_nolock", 32'(locked),  32'd0);
        chk("t6_errcnt", 32'(err_cnt), 32'd0);
`ifdef LFSR_CHK_STATS_EN
        chk("t6_words",  word_cnt,     32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
